// File: rtl/float_pkg.sv
// Shared float datapath types plus the leading-zero helper used when
// renormalising adder results.
package float_pkg;
   localparam int FLOAT_W = 32;
   typedef logic [FLOAT_W-1:0] float_t;

   function automatic logic [4:0] lzc27(input logic [26:0] v);
      logic [4:0] n;
      logic       done;
      n    = 5'd0;
      done = 1'b0;
      for (int i = 26; i >= 0; i--) begin
         if (!done && v[i]) begin
            done = 1'b1;
         end else if (!done) begin
            n = n + 5'd1;
         end else begin
            n = n;
         end
      end
      return n;
   endfunction
endpackage

// File: rtl/float_addsub.sv
// Two-stage IEEE-754 single add/subtract (op=1 subtracts v2), round to nearest
// even; zero/denormal inputs read as zero, overflow gives infinity.
module float_addsub
   import float_pkg::*;
(
   input  logic   clk,
   input  float_t v1,
   input  float_t v2,
   input  logic   op,
   output float_t vres
);

   logic        sign_b_s, swap_s, sticky_s;
   logic [7:0]  big_e_s, small_e_s, dist_s;
   logic [26:0] man_a_s, man_b_s, big_m_s, small_m_s, sh_s;
   logic        s1_sign_d, s1_sign_q;
   logic [7:0]  s1_exp_d, s1_exp_q;
   logic [27:0] s1_sum_d, s1_sum_q;

   assign sign_b_s = v2[31] ^ op;
   assign man_a_s  = (v1[30:23] == 8'd0) ? 27'd0 : {1'b1, v1[22:0], 3'b000};
   assign man_b_s  = (v2[30:23] == 8'd0) ? 27'd0 : {1'b1, v2[22:0], 3'b000};
   assign swap_s   = ({v2[30:23], man_b_s} > {v1[30:23], man_a_s});

   // Stage 1: order by magnitude, align with sticky, add or subtract magnitudes
   always_comb begin
      if (swap_s) begin
         s1_sign_d = sign_b_s;
         big_e_s   = v2[30:23];
         big_m_s   = man_b_s;
         small_e_s = v1[30:23];
         small_m_s = man_a_s;
      end else begin
         s1_sign_d = v1[31];
         big_e_s   = v1[30:23];
         big_m_s   = man_a_s;
         small_e_s = v2[30:23];
         small_m_s = man_b_s;
      end
      s1_exp_d = big_e_s;
      dist_s   = big_e_s - small_e_s;
      if (dist_s >= 8'd27) begin
         sh_s     = 27'd0;
         sticky_s = |small_m_s;
      end else begin
         sh_s     = small_m_s >> dist_s;
         sticky_s = |(small_m_s & ((27'd1 << dist_s) - 27'd1));
      end
      sh_s = sh_s | {26'd0, sticky_s};
      if (v1[31] == sign_b_s) begin
         s1_sum_d = {1'b0, big_m_s} + {1'b0, sh_s};
      end else begin
         s1_sum_d = {1'b0, big_m_s} - {1'b0, sh_s};
      end
   end

   // Stage 1 pipeline register
   always_ff @(posedge clk) begin
      s1_sign_q <= s1_sign_d;
      s1_exp_q  <= s1_exp_d;
      s1_sum_q  <= s1_sum_d;
   end

   logic [4:0]  lz_s;
   logic [26:0] norm_s;
   logic [24:0] mr_s;
   logic        rnd_s;
   int          exp_s;
   float_t      vres_d;

   assign lz_s = lzc27(s1_sum_q[26:0]);

   // Stage 2: renormalise, round to nearest even, pack
   always_comb begin
      norm_s = 27'd0;
      exp_s  = 0;
      rnd_s  = 1'b0;
      mr_s   = 25'd0;
      vres_d = 32'd0;
      if (s1_sum_q == 28'd0) begin
         vres_d = 32'd0;
      end else begin
         if (s1_sum_q[27]) begin
            norm_s = {s1_sum_q[27:2], s1_sum_q[1] | s1_sum_q[0]};
            exp_s  = int'(s1_exp_q) + 1;
         end else begin
            norm_s = s1_sum_q[26:0] << lz_s;
            exp_s  = int'(s1_exp_q) - int'(lz_s);
         end
         rnd_s = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
         mr_s  = {1'b0, norm_s[26:3]} + {24'd0, rnd_s};
         exp_s = exp_s + int'(mr_s[24]);
         if (exp_s <= 0) begin
            vres_d = 32'd0;
         end else if (exp_s >= 255) begin
            vres_d = {s1_sign_q, 8'hFF, 23'd0};
         end else begin
            vres_d = {s1_sign_q, exp_s[7:0], mr_s[22:0]};
         end
      end
   end

   // Stage 2 result register
   always_ff @(posedge clk) begin
      vres <= vres_d;
   end

endmodule

// File: rtl/float_addsub_rr_arbiter.sv
// Combinational round-robin arbiter: the first requesting index at or after
// ptr (wrapping) wins.
module rr_arbiter #(
   parameter int N   = 4,
   parameter int IDW = $clog2(N)
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] gnt_id
);

   // Rotating priority search starting at ptr
   always_comb begin
      logic [IDW:0]   pos;
      logic [IDW-1:0] idx;
      logic           found;
      gnt    = '0;
      gnt_id = '0;
      found  = 1'b0;
      for (int k = 0; k < N; k++) begin
         pos = {1'b0, ptr} + (IDW+1)'(k);
         if (pos >= (IDW+1)'(N)) begin
            pos = pos - (IDW+1)'(N);
         end else begin
            pos = pos;
         end
         idx = pos[IDW-1:0];
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            gnt_id   = idx;
            found    = 1'b1;
         end else begin
            found = found;
         end
      end
   end

endmodule

// File: rtl/float_addsub_sched.sv
// Round-robin scheduler sharing one float_addsub among N requesters; each
// result comes back tagged with the ID of the requester that issued it.
module float_addsub_sched
   import float_pkg::*;
#(
   parameter int N      = 4,
   parameter int FU_LAT = 2,
   parameter int IDW    = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hold,
   input  logic [N-1:0]     req_valid,
   output logic [N-1:0]     req_ready,
   input  logic [N*32-1:0]  req_v1,
   input  logic [N*32-1:0]  req_v2,
   input  logic [N-1:0]     req_op,
   output logic             resp_valid,
   output logic [IDW-1:0]   resp_id,
   output float_t           resp_data,
   output logic             busy
);

   logic [N-1:0]   arb_req_s, gnt_s;
   logic [IDW-1:0] gnt_id_s;
   logic           hs_s;

   logic [IDW-1:0] ptr_q, ptr_d, iss_id_q, iss_id_d;
   logic           iss_vld_q, iss_vld_d, iss_op_q, iss_op_d;
   float_t         iss_v1_q, iss_v1_d, iss_v2_q, iss_v2_d;
   logic [FU_LAT-1:0]          tag_vld_q;
   logic [FU_LAT-1:0][IDW-1:0] tag_id_q;

   assign arb_req_s = (rst || hold) ? '0 : req_valid;
   assign req_ready = gnt_s;
   assign hs_s      = |(req_valid & gnt_s);

   rr_arbiter #(.N(N), .IDW(IDW)) u_arb (
      .req    (arb_req_s),
      .ptr    (ptr_q),
      .gnt    (gnt_s),
      .gnt_id (gnt_id_s)
   );

   // Issue register and pointer next state; operands stay stale when idle
   always_comb begin
      ptr_d     = ptr_q;
      iss_vld_d = 1'b0;
      iss_id_d  = iss_id_q;
      iss_op_d  = iss_op_q;
      iss_v1_d  = iss_v1_q;
      iss_v2_d  = iss_v2_q;
      if (hs_s) begin
         ptr_d     = (gnt_id_s == IDW'(N-1)) ? '0 : gnt_id_s + IDW'(1);
         iss_vld_d = 1'b1;
         iss_id_d  = gnt_id_s;
         iss_op_d  = req_op[gnt_id_s];
         iss_v1_d  = req_v1[int'(gnt_id_s)*FLOAT_W +: FLOAT_W];
         iss_v2_d  = req_v2[int'(gnt_id_s)*FLOAT_W +: FLOAT_W];
      end else begin
         ptr_d = ptr_q;
      end
   end

   // Issue register, pointer and tag shift register
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q     <= '0;
         iss_vld_q <= 1'b0;
         iss_id_q  <= '0;
         iss_op_q  <= 1'b0;
         iss_v1_q  <= '0;
         iss_v2_q  <= '0;
         tag_vld_q <= '0;
         tag_id_q  <= '0;
      end else begin
         ptr_q       <= ptr_d;
         iss_vld_q   <= iss_vld_d;
         iss_id_q    <= iss_id_d;
         iss_op_q    <= iss_op_d;
         iss_v1_q    <= iss_v1_d;
         iss_v2_q    <= iss_v2_d;
         tag_vld_q[0] <= iss_vld_q;
         tag_id_q[0]  <= iss_id_q;
         for (int i = 1; i < FU_LAT; i++) begin
            tag_vld_q[i] <= tag_vld_q[i-1];
            tag_id_q[i]  <= tag_id_q[i-1];
         end
      end
   end

   // FU_LAT must equal the fixed latency of float_addsub (two stages)
   float_addsub u_fu (
      .clk  (clk),
      .v1   (iss_v1_q),
      .v2   (iss_v2_q),
      .op   (iss_op_q),
      .vres (resp_data)
   );

   assign resp_valid = tag_vld_q[FU_LAT-1];
   assign resp_id    = tag_id_q[FU_LAT-1];
   assign busy       = iss_vld_q | (|tag_vld_q);

endmodule

// File: tb/tb_float_addsub_sched.sv
// Directed bench for float_addsub_sched against a queue-based scheduler model
// and a real-arithmetic float model.
module tb_float_addsub_sched;
   localparam int N = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst, hold;
   logic [N-1:0]    req_valid, req_ready, req_op;
   logic [N*32-1:0] req_v1, req_v2;
   logic            resp_valid, busy;
   logic [1:0]      resp_id;
   logic [31:0]     resp_data;

   float_addsub_sched #(.N(N), .FU_LAT(2)) dut (
      .clk(clk), .rst(rst), .hold(hold),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_v1(req_v1), .req_v2(req_v2), .req_op(req_op),
      .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
      .busy(busy)
   );

   typedef struct { int id; logic [31:0] data; int due; } exp_t;
   exp_t        q[$];
   int          gnt_log[$];
   int          cyc = 0, m_ptr = 0, checks = 0, errors = 0;
   int          resp_count = 0, last_id = -1, base;
   logic [31:0] last_data = 32'd0;
   logic [N-1:0] exp_rdy = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic real f2r(input logic [31:0] b);
      real m;
      int  e;
      if (b[30:23] == 8'd0) return 0.0;
      m = 1.0 + real'(b[22:0]) / 8388608.0;
      e = int'(b[30:23]) - 127;
      while (e > 0) begin m = m * 2.0; e--; end
      while (e < 0) begin m = m / 2.0; e++; end
      return b[31] ? -m : m;
   endfunction

   function automatic logic [31:0] r2f(input real x);
      logic [63:0] d;
      logic [23:0] m;
      logic [28:0] rest;
      int          e;
      if (x == 0.0) return 32'd0;
      d    = $realtobits(x);
      e    = int'(d[62:52]) - 1023 + 127;
      m    = {1'b1, d[51:29]};
      rest = d[28:0];
      if (rest > 29'h10000000 || (rest == 29'h10000000 && m[0])) m = m + 24'd1;
      if (m == 24'd0) e++;
      return {d[63], e[7:0], m[22:0]};
   endfunction

   function automatic logic [31:0] fadd_model(input logic [31:0] a, input logic [31:0] b, input logic op);
      return r2f(f2r(a) + (op ? -f2r(b) : f2r(b)));
   endfunction

   // Compare process: outputs versus model on every cycle
   always @(negedge clk) begin
      exp_rdy = '0;
      if (!rst && !hold) begin
         for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (req_valid[i] && exp_rdy == '0) exp_rdy[i] = 1'b1;
         end
      end
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("busy", 32'(busy), (q.size() > 0) ? 32'd1 : 32'd0);
      if (q.size() > 0 && q[0].due == cyc) begin
         chk("resp_valid", 32'(resp_valid), 32'd1);
         chk("resp_id", 32'(resp_id), q[0].id);
         chk("resp_data", resp_data, q[0].data);
         last_id   = int'(resp_id);
         last_data = resp_data;
         resp_count++;
         void'(q.pop_front());
      end else begin
         chk("resp_valid_idle", 32'(resp_valid), 32'd0);
      end
   end

   // Model state update at each active edge
   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         q.delete();
         m_ptr = 0;
      end else if (exp_rdy != '0) begin
         int g;
         exp_t e;
         g = 0;
         for (int k = 0; k < N; k++) if (exp_rdy[k]) g = k;
         e.id   = g;
         e.data = fadd_model(req_v1[g*32 +: 32], req_v2[g*32 +: 32], req_op[g]);
         e.due  = cyc + 2;
         q.push_back(e);
         gnt_log.push_back(g);
         m_ptr = (g + 1) % N;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic op);
      req_v1[i*32 +: 32] = a;
      req_v2[i*32 +: 32] = b;
      req_op[i]          = op;
   endtask

   logic [31:0] vec_a [5] = '{32'h3F800000, 32'h3F800000, 32'h3FC00000, 32'h40490FDB, 32'hC1200000};
   logic [31:0] vec_b [5] = '{32'h33800000, 32'h33C00000, 32'h3E800000, 32'h402DF854, 32'h41200001};
   logic        vec_o [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

   initial begin
      rst = 1'b1; hold = 1'b0; req_valid = '1; req_op = '0; req_v1 = '0; req_v2 = '0;
      chk("pin_single", fadd_model(32'hC0E80000, 32'hC2F6CCCD, 1'b0), 32'hC302A666);
      chk("pin_sub",    fadd_model(32'h3FC00000, 32'h3E800000, 1'b1), 32'h3FA00000);
      chk("pin_tie",    fadd_model(32'h3F800000, 32'h33800000, 1'b0), 32'h3F800000);
      chk("pin_up",     fadd_model(32'h3F800000, 32'h33C00000, 1'b0), 32'h3F800001);
      chk("pin_cancel", fadd_model(32'hC1200000, 32'h41200001, 1'b0), 32'h35800000);
      tick(3);
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_resp_id", 32'(resp_id), 32'd0);
      tick(1);
      req_valid = '0; rst = 1'b0;
      tick(1);

      // Single request from requester 2
      base = resp_count;
      set_req(2, 32'hC0E80000, 32'hC2F6CCCD, 1'b0);
      req_valid = 4'b0100;
      @(negedge clk);
      chk("single_ready", 32'(req_ready), 32'h4);
      tick(1);
      req_valid = '0;
      tick(5);
      chk("single_count", resp_count - base, 32'd1);
      chk("single_id", last_id, 32'd2);
      chk("single_data", last_data, 32'hC302A666);

      // All-valid fairness from reset
      rst = 1'b1; tick(1); rst = 1'b0;
      gnt_log.delete(); base = resp_count;
      for (int i = 0; i < N; i++)
         set_req(i, 32'h3F800000 + 32'(i) * 32'h00100000, 32'h40000000 + 32'(i) * 32'h00080000, i[0]);
      req_valid = '1;
      tick(12);
      req_valid = '0;
      tick(5);
      chk("fair_count", resp_count - base, 32'd12);
      chk("fair_grants", gnt_log.size(), 32'd12);
      for (int i = 0; i < 12 && i < gnt_log.size(); i++) chk("fair_order", gnt_log[i], i % 4);

      // Back-to-back single requester
      gnt_log.delete(); base = resp_count;
      req_valid = 4'b0010;
      for (int j = 0; j < 5; j++) begin
         set_req(1, vec_a[j], vec_b[j], vec_o[j]);
         tick(1);
      end
      req_valid = '0;
      tick(5);
      chk("b2b_count", resp_count - base, 32'd5);
      for (int i = 0; i < gnt_log.size(); i++) chk("b2b_grant", gnt_log[i], 32'd1);
      chk("b2b_last_data", last_data, 32'h35800000);

      // Hold keeps pointer and lets in-flight work finish
      gnt_log.delete(); base = resp_count;
      set_req(0, 32'h40400000, 32'h3F000000, 1'b0);
      set_req(3, 32'h41000000, 32'h40800000, 1'b1);
      req_valid = 4'b1001;
      tick(1);
      hold = 1'b1;
      tick(4);
      hold = 1'b0;
      tick(2);
      req_valid = '0;
      tick(5);
      chk("hold_grants", gnt_log.size(), 32'd3);
      if (gnt_log.size() == 3) begin
         chk("hold_g0", gnt_log[0], 32'd3);
         chk("hold_g1", gnt_log[1], 32'd0);
         chk("hold_g2", gnt_log[2], 32'd3);
      end else begin
         chk("hold_log", gnt_log.size(), 32'd3);
      end
      chk("hold_count", resp_count - base, 32'd3);

      // Reset with two ops in flight
      gnt_log.delete();
      set_req(1, 32'h3F800000, 32'h3F800000, 1'b0);
      set_req(2, 32'h40000000, 32'h3F800000, 1'b1);
      req_valid = 4'b0110;
      tick(2);
      base = resp_count;
      req_valid = '0; rst = 1'b1;
      tick(1);
      rst = 1'b0; req_valid = 4'b1010;
      @(negedge clk);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      tick(1);
      req_valid = '0;
      tick(5);
      chk("mid_rst_count", resp_count - base, 32'd1);
      chk("mid_rst_id", last_id, 32'd1);
      chk("mid_rst_grants", gnt_log.size(), 32'd3);
      if (gnt_log.size() == 3) chk("mid_rst_first", gnt_log[2], 32'd1);
      else chk("mid_rst_log", gnt_log.size(), 32'd3);

      // Wrap between requesters 3 and 0
      gnt_log.delete();
      req_valid = 4'b1001;
      tick(4);
      req_valid = '0;
      tick(5);
      chk("wrap_grants", gnt_log.size(), 32'd4);
      for (int i = 0; i < gnt_log.size(); i++) chk("wrap_order", gnt_log[i], (i % 2 == 0) ? 32'd3 : 32'd0);

      chk("drain", q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/float_addsub_sched.md
# float_addsub_sched

Round-robin scheduler that shares one `float_addsub` unit among `N` requesters. Each requester offers an operand pair and op code over a valid/ready handshake. The scheduler grants at most one request per cycle, registers it into the unit, and tracks the requester ID through the unit's fixed pipeline. It returns each result tagged with that ID. It sits between the client blocks and the single `float_addsub` instance in the float datapath.

## Interface
Parameters:
- `N`, 4: number of requesters (2..8).
- `FU_LAT`, 2: cycles from `float_addsub` inputs changing to `vres` valid (clocked on `clk`).
- `IDW`, `$clog2(N)`: width of the requester ID.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `hold` in 1: when 1, no new grants; in-flight ops drain normally.
- `req_valid` in N: request pending, one bit per requester.
- `req_ready` out N: grant, one-hot or zero; handshake completes when `req_valid[i] & req_ready[i]`.
- `req_v1` in N*32: operand 1; requester i uses slice [32i+31:32i].
- `req_v2` in N*32: operand 2, same packing.
- `req_op` in N: op bit per requester, passed unchanged to `float_addsub.op`.
- `resp_valid` out 1: one-cycle pulse, result available.
- `resp_id` out IDW: requester that issued the result.
- `resp_data` out 32: `float_addsub.vres` for that request.
- `busy` out 1: 1 while any op is in the issue register or FU pipeline.

## Operation
- Arbitration is combinational round-robin over `req_valid`, masked by `hold`.
  - Search starts at pointer `ptr`; the first valid index wins.
  - `req_ready` is a function of `req_valid`, `hold` and `ptr` only.
  - `req_ready[i]` may depend on `req_valid[i]`, so requesters must not make `valid` wait on `ready`.
- On a handshake with requester g, in the same cycle:
  - capture `v1`, `v2`, `op` and ID g into the issue register (`iss_vld`=1);
  - set `ptr` ← (g+1) mod N.
- With no handshake, `ptr` is unchanged and `iss_vld` ← 0.
  - The issue register holds its last operands; the FU sees stale data, and its result is suppressed because the tag is invalid.
- The issue register drives `float_addsub` `v1`/`v2`/`op` directly.
- Tag pipeline: a shift register `FU_LAT` deep carrying {`vld`, `id`}, fed from {`iss_vld`, `iss_id`}. Its tail drives `resp_valid`/`resp_id`, and `resp_data` = `vres`.
- No output backpressure: consumers must accept `resp_valid` pulses unconditionally.
- Throughput: one op per cycle sustained; with all requesters valid, each is granted once every N cycles.
- `busy` = `iss_vld` OR any tag `vld`.

## Timing
- Handshake at edge k → `resp_valid`=1 during cycle k+1+`FU_LAT` (default: 3 cycles after the accepting edge).
- Responses return in grant order; there is no reordering.
- Reset values: `req_ready`=0 while `rst`=1; `ptr`=0; `iss_vld`=0; all tag `vld`=0; `resp_valid`=0; `resp_id`=0; `busy`=0.
- Reset mid-operation:
  - all in-flight ops are discarded and no `resp_valid` follows for them;
  - the first grant after `rst` deasserts goes to the lowest valid index at or above 0.
- `hold` asserted at edge k: no handshake at k; ops already accepted still complete.
- `hold` does not move `ptr`.
- A single active requester is granted every cycle (back-to-back issue).
- A requester dropping `req_valid` without a handshake is legal; no grant is lost.
- `ptr` wrap: after a grant to N−1, `ptr`=0.

## Structure
- Shared package `float_pkg`: `FLOAT_W`=32 and a typedef `float_t` (32-bit).
- Natural sub-module: `rr_arbiter` (parameter N; inputs `req`, `ptr`; outputs one-hot `gnt` and encoded `gnt_id`), purely combinational.
- `float_addsub` is instantiated unchanged inside this block.

## Test plan
- **Single request:** requester 2 offers v1=0xC0E80000 (−7.25), v2=0xC2F6CCCD (−123.4), op=0 at edge 5 → `req_ready[2]` high at edge 5; `resp_valid` at cycle 8 with `resp_id`=2 and `resp_data`=0xC302A666 (−130.65).
- **All-valid fairness:** all 4 requesters valid for 12 cycles from reset → grant order 0,1,2,3,0,1,2,3,…; 12 responses tagged in the same order, each exactly 3 cycles after its grant.
- **Back-to-back single requester:** requester 1 valid for 5 cycles with distinct operands → 5 consecutive `resp_valid` pulses, data matching each operand set in order.
- **Hold:** assert `hold` for 4 cycles with requesters 0 and 3 valid → no `req_ready`; in-flight ops still respond; after release the grant resumes at the saved `ptr`.
- **Reset mid-flight:** 2 ops in flight, assert `rst` for 1 cycle → no `resp_valid` for either op, `busy`=0 the cycle after reset, next grant goes to the lowest valid index.
- **Wrap:** only requesters 3 and 0 valid → grants alternate 3,0,3,0.
